muldiv_seq: RTL

- Multi-cycle sequencer for the RV32M multiply/divide operations.
- Replaces the single-cycle combinational MUL/DIV/REM paths with a shared shift-add / restoring-divide iterator.
- Sits beside the integer ALU in EX. The pipeline stalls while ready_o is low and captures result_o on the valid_o pulse.
- Results are bit-exact to the RISC-V M spec, including divide-by-zero and signed overflow.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_operand_prep.sv | 52 +++++
 rtl/muldiv_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit:
// funct3 encodings, sequencer states and the special-case result constants.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int XLEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN_DEF-1:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational decode of funct3 and operands: magnitudes, sign flags and
// the divide special cases that bypass the iterator.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opr_1,
  input  logic [XLEN-1:0] opr_2,
  output logic [XLEN-1:0] mag_1,
  output logic [XLEN-1:0] mag_2,
  output logic            sign_1,
  output logic            sign_2,
  output logic            is_div,
  output logic            is_rem,
  output logic            high_half,
  output logic            div_by_zero,
  output logic            overflow
);

  logic signed_1;
  logic signed_2;

  always_comb begin
    signed_1 = 1'b0;
    signed_2 = 1'b0;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        signed_1 = 1'b1;
        signed_2 = 1'b1;
      end
      OP_MULHSU: signed_1 = 1'b1;
      default: ;
    endcase
  end

  assign sign_1 = signed_1 & opr_1[XLEN-1];
  assign sign_2 = signed_2 & opr_2[XLEN-1];
  // INT_MIN negates to itself, which is still the correct unsigned magnitude
  assign mag_1  = sign_1 ? -opr_1 : opr_1;
  assign mag_2  = sign_2 ? -opr_2 : opr_2;

  assign is_div    = op[2];
  assign is_rem    = op[2] & op[1];
  assign high_half = ~op[2] & (op[1:0] != 2'b00);

  assign div_by_zero = is_div && (opr_2 == '0);
  assign overflow    = ((op == OP_DIV) || (op == OP_REM)) &&
                       (opr_1 == INT_MIN) && (opr_2 == ALL_ONES);

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: one shared iterator does shift-add multiply
// and restoring divide, one result bit per CALC cycle, signs applied in FIXUP.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] opr_1_i,
  input  logic [XLEN-1:0] opr_2_i,
  input  logic            kill_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  state_t state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic [2*XLEN-1:0] a_reg;
  logic [XLEN-1:0]   b_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   result_reg;
  logic              sign1_reg, sign2_reg;
  logic              is_div_reg, is_rem_reg, high_reg;

  logic [XLEN-1:0] mag_1, mag_2;
  logic            sign_1, sign_2, is_div, is_rem, high_half;
  logic            div_by_zero, overflow, special, accept;
  logic [XLEN-1:0] special_res;

  muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
    .op          (op_i),
    .opr_1       (opr_1_i),
    .opr_2       (opr_2_i),
    .mag_1       (mag_1),
    .mag_2       (mag_2),
    .sign_1      (sign_1),
    .sign_2      (sign_2),
    .is_div      (is_div),
    .is_rem      (is_rem),
    .high_half   (high_half),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  assign ready_o  = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign valid_o  = (state_reg == S_DONE);
  assign result_o = result_reg;
  assign accept   = start_i && ready_o && !kill_i;
  assign special  = div_by_zero || overflow;

  always_comb begin
    special_res = div_by_zero ? ALL_ONES : INT_MIN;
    if (is_rem) special_res = div_by_zero ? opr_1_i : '0;
  end

  // Iteration step for both operations
  logic [2*XLEN-1:0] mul_next, div_next, acc_step;
  logic [XLEN:0]     rem_sh, rem_diff;

  always_comb begin
    mul_next = b_reg[0] ? (acc_reg + a_reg) : acc_reg;
    rem_sh   = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    rem_diff = rem_sh - {1'b0, b_reg};
    if (rem_diff[XLEN]) div_next = {rem_sh[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    else                div_next = {rem_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    acc_step = is_div_reg ? div_next : mul_next;
  end

  // Sign correction and result selection; the divide keeps rem:quot in acc
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = (sign1_reg ^ sign2_reg) ? -acc_reg : acc_reg;
    quot_fix = (sign1_reg ^ sign2_reg) ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem_fix  = sign1_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    if (is_div_reg)    fix_res = is_rem_reg ? rem_fix : quot_fix;
    else if (high_reg) fix_res = prod_fix[2*XLEN-1:XLEN];
    else               fix_res = prod_fix[XLEN-1:0];
  end

  always_comb begin
    state_next = state_reg;
    if (kill_i) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start_i) state_next = special ? S_DONE : S_CALC;
          else         state_next = S_IDLE;
        end
        S_CALC:  if (cnt_reg == CNT_LAST) state_next = S_FIXUP;
        S_FIXUP: state_next = S_DONE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      sign1_reg  <= 1'b0;
      sign2_reg  <= 1'b0;
      is_div_reg <= 1'b0;
      is_rem_reg <= 1'b0;
      high_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg    <= '0;
        sign1_reg  <= sign_1;
        sign2_reg  <= sign_2;
        is_div_reg <= is_div;
        is_rem_reg <= is_rem;
        high_reg   <= high_half;
        b_reg      <= mag_2;
        a_reg      <= is_div ? '0 : {{XLEN{1'b0}}, mag_1};
        acc_reg    <= is_div ? {{XLEN{1'b0}}, mag_1} : '0;
        if (special) result_reg <= special_res;
      end else if (!kill_i && state_reg == S_CALC) begin
        acc_reg <= acc_step;
        a_reg   <= a_reg << 1;
        if (!is_div_reg) b_reg <= b_reg >> 1;
        if (cnt_reg != CNT_LAST) cnt_reg <= cnt_reg + 1'b1;
      end else if (!kill_i && state_reg == S_FIXUP) begin
        result_reg <= fix_res;
      end
    end
  end

endmodule
